power_on_reset_sequencer: RTL
=============================

POWER_ON_RESET_SEQUENCER -- requirements
Module: power_on_reset_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is rst_n.
REQ-002 Parameter SYNC_STAGES, default 2: number of reset-release synchronizer flops (legal values 2 or more).
REQ-003 Parameter HOLD_CYCLES, default 16: cycles por_reset stays high in HOLD (legal values 1 or more).
REQ-004 Parameter RELEASE_TIMEOUT, default 64: maximum cycles spent in RELEASE waiting for cu_ready (legal values 1 or more).
REQ-005 Parameter MAX_RETRIES, default 3: number of RELEASE timeouts that forces FAULT (legal values 1 or more).
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 cu_ready  input  1  control unit reports it is out of reset and running; synchronous to clk.
REQ-009 por_restart  input  1  single-cycle request to rerun the sequence; synchronous to clk.
REQ-010 por_reset  output  1  active-high reset; feeds the data input of the downstream power-on-reset selector.
REQ-011 por_sel  output  1  high while this block owns the system reset; drives the select input of the downstream selector.
REQ-012 por_done  output  1  high while in DONE.
REQ-013 por_fault  output  1  high while in FAULT.
REQ-014 state_o  output  3  current state encoding: ASSERT=0, HOLD=1, RELEASE=2, DONE=3, FAULT=4.

Function
REQ-015 All outputs SHALL be registered or decoded directly from state registers, with no combinational path from cu_ready or por_restart to any output.
REQ-016 The synchronizer chain SHALL be cleared asynchronously by rst_n low and SHALL shift in 1 on each clk edge while rst_n is high; its output is the last stage.
REQ-017 ASSERT: por_reset=1, por_sel=1; ASSERT goes to HOLD at the first edge where the synchronizer output is sampled 1, with hold_cnt=0.
REQ-018 HOLD: por_reset=1, por_sel=1; hold_cnt increments each cycle; HOLD goes to RELEASE at the edge where hold_cnt==HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-019 RELEASE: por_reset=0, por_sel=1; tmo_cnt starts at 0 and increments each cycle; cu_ready sampled 1 moves RELEASE to DONE at the next edge.
REQ-020 RELEASE timeout: when tmo_cnt==RELEASE_TIMEOUT-1 and cu_ready=0, retry_cnt increments; the next state is FAULT if the new retry_cnt equals MAX_RETRIES, otherwise HOLD with hold_cnt=0.
REQ-021 If cu_ready=1 on the same edge as a timeout, cu_ready SHALL win: the next state is DONE and retry_cnt is unchanged.
REQ-022 DONE: por_reset=0, por_sel=0, por_done=1; retry_cnt is cleared on entry to DONE.
REQ-023 por_restart=1 in DONE moves the state to HOLD at the next edge with hold_cnt=0 and retry_cnt=0; por_restart in any other state SHALL be ignored with no effect on counters.
REQ-024 FAULT: por_reset=1, por_sel=1, por_fault=1; FAULT is exited only by rst_n.
REQ-025 Counter widths SHALL be the minimum sufficient for max(HOLD_CYCLES, RELEASE_TIMEOUT) and for MAX_RETRIES; no counter may wrap.
REQ-026 Undefined state encodings SHALL go to ASSERT at the next edge.

Reset
REQ-027 rst_n low, at any time and in any state, SHALL immediately and asynchronously force: state=ASSERT, por_reset=1, por_sel=1, por_done=0, por_fault=0, state_o=0, all counters and synchronizer flops 0.
REQ-028 rst_n deassertion SHALL take effect on outputs only through the synchronizer, never directly.

Verification
REQ-029 Default parameters, cu_ready=1, rst_n rises before edge 1 -> HOLD entered at edge 3, por_reset falls at edge 19, DONE at edge 20, then por_sel=0 and por_done=1.
REQ-030 cu_ready=0 throughout -> three cycles of 16 HOLD cycles plus 64 RELEASE cycles, then FAULT with por_fault=1, por_reset=1, por_sel=1, state_o=4, held until rst_n.
REQ-031 In DONE, 1-cycle por_restart pulse -> next edge state_o=1, por_reset=1, por_sel=1; 16 HOLD cycles follow; retry_cnt=0.
REQ-032 por_restart pulsed at HOLD cycle 5 -> ignored; por_reset still falls after exactly 16 HOLD cycles.
REQ-033 rst_n dropped mid-HOLD (hold_cnt=9) -> same-time return to reset values with no clk edge needed; after release, full 2+16 cycle sequence repeats.
REQ-034 cu_ready rises on the timeout cycle (tmo_cnt=63) of the first RELEASE -> DONE, retry_cnt=0, por_fault=0.

Source files
------------

// File: rtl/power_on_reset_sequencer.sv
// Power-on reset sequencer: synchronizes rst_n release, holds the system in reset,
// then waits for the control unit, retrying a bounded number of times before faulting.
module power_on_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
  parameter int RELEASE_TIMEOUT = 64,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cu_ready,
  input  logic       por_restart,
  output logic       por_reset,
  output logic       por_sel,
  output logic       por_done,
  output logic       por_fault,
  output logic [2:0] state_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > RELEASE_TIMEOUT) ? HOLD_CYCLES : RELEASE_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [RW-1:0]          retry_cnt, retry_nxt;
  logic [RW-1:0]          retry_inc;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_out;

  // Release of rst_n reaches the FSM only via this chain, so deassertion is always clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_out  = sync_pipe[SYNC_STAGES-1];
  assign retry_inc = retry_cnt + RW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // One counter serves as hold_cnt in HOLD and tmo_cnt in RELEASE; it is zeroed on every entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    case (state)
      ST_ASSERT: begin
        cnt_nxt = '0;
        if (sync_out) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (cu_ready) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else if (cnt == CW'(RELEASE_TIMEOUT - 1)) begin
          retry_nxt = retry_inc;
          cnt_nxt   = '0;
          state_nxt = (retry_inc == RW'(MAX_RETRIES)) ? ST_FAULT : ST_HOLD;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DONE: begin
        if (por_restart) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
        retry_nxt = '0;
      end
    endcase
  end

  // Outputs decode the state register only; no input reaches them combinationally.
  always_comb begin
    por_reset = 1'b1;
    por_sel   = 1'b1;
    por_done  = 1'b0;
    por_fault = 1'b0;
    case (state)
      ST_RELEASE: por_reset = 1'b0;
      ST_DONE: begin
        por_reset = 1'b0;
        por_sel   = 1'b0;
        por_done  = 1'b1;
      end
      ST_FAULT: por_fault = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
